// File: rtl/core_sequencer.sv
// core_sequencer: valid/ready command front-end that iterates core_system and returns the result.
// Optional sticky overflow status is enabled by defining CORE_SEQ_STICKY_OVF_EN.

module core_system (
  input  logic [2:0] op,
  input  logic [3:0] in_1,
  input  logic [3:0] in_2,
  output logic [3:0] out,
  output logic       overflow
);

  logic [3:0] sum;
  logic [3:0] diff;

  assign sum  = in_1 + in_2;
  assign diff = in_1 - in_2;

  // Overflow is two's-complement signed overflow of the arithmetic ops only.
  always_comb begin
    out      = 4'd0;
    overflow = 1'b0;
    case (op)
      3'd0: out = in_1 & in_2;
      3'd1: out = in_1 | in_2;
      3'd2: out = in_1 ^ in_2;
      3'd3: out = ~in_1;
      3'd4: out = in_1;
      3'd5: begin
        out      = diff;
        overflow = (in_1[3] != in_2[3]) && (diff[3] != in_1[3]);
      end
      3'd6: begin
        out      = sum;
        overflow = (in_1[3] == in_2[3]) && (sum[3] != in_1[3]);
      end
      default: out = in_2;
    endcase
  end

endmodule

module core_sequencer #(
  parameter int         RPT_W    = 4,
  parameter logic [3:0] ACC_INIT = 4'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic [RPT_W-1:0] cmd_rpt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_ovf,
  input  logic             clr_ovf,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [2:0]       op_r;
  logic [3:0]       a_r;
  logic [3:0]       b_r;
  logic [RPT_W-1:0] cnt;
  logic [3:0]       acc;
  logic             ovf_acc;
  logic [3:0]       core_out;
  logic             core_ovf;
  logic             accept;
  logic             last_iter;

  core_system u_core (
    .op       (op_r),
    .in_1     (a_r),
    .in_2     (b_r),
    .out      (core_out),
    .overflow (core_ovf)
  );

  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign last_iter = (state == RUN) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid) next_state = RUN;
      RUN:     if (cnt == '0) next_state = DONE;
      DONE:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Each RUN cycle feeds the ALU result back as the next first operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 3'd0;
      a_r      <= 4'd0;
      b_r      <= 4'd0;
      cnt      <= '0;
      acc      <= ACC_INIT;
      ovf_acc  <= 1'b0;
      res_data <= 4'd0;
      res_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r    <= cmd_op;
            b_r     <= cmd_b;
            a_r     <= cmd_use_acc ? acc : cmd_a;
            cnt     <= cmd_rpt;
            ovf_acc <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= core_out;
          ovf_acc <= ovf_acc | core_ovf;
          if (cnt == '0) begin
            res_data <= core_out;
            res_ovf  <= ovf_acc | core_ovf;
            acc      <= core_out;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CORE_SEQ_STICKY_OVF_EN
  logic sticky_r;

  // A completing overflow takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           sticky_r <= 1'b0;
    else if (last_iter && (ovf_acc | core_ovf)) sticky_r <= 1'b1;
    else if (clr_ovf)                     sticky_r <= 1'b0;
  end

  assign ovf_sticky = sticky_r;
`else
  logic unused_clr_ovf;
  logic unused_last_iter;

  assign unused_clr_ovf   = clr_ovf;
  assign unused_last_iter = last_iter;
  assign ovf_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed vector table, multi-cycle corner sequences
// and randomized commands checked against a signed-arithmetic reference model.

module tb_core_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_acc;
  logic [3:0] cmd_rpt;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_ovf;
  logic       clr_ovf;
  logic       ovf_sticky;

  int total;
  int bad;
  int acc_m;
  int sticky_m;

  typedef struct {
    int op;
    int a;
    int b;
    int ua;
    int rpt;
    int exp_data;
    int exp_ovf;
  } vec_t;

  vec_t vecs[8];

  core_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .cmd_rpt     (cmd_rpt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_ovf     (res_ovf),
    .clr_ovf     (clr_ovf),
    .ovf_sticky  (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: N+1 signed 4-bit add/sub steps with plain integer arithmetic.
  function automatic void modelRun(input int op, input int a0, input int b, input int rpt,
                                   output int data, output int ovf);
    int val, sa, sb, r;
    val = a0;
    ovf = 0;
    for (int i = 0; i <= rpt; i++) begin
      sa = (val > 7) ? val - 16 : val;
      sb = (b > 7) ? b - 16 : b;
      r  = (op == 6) ? sa + sb : sa - sb;
      if (r > 7 || r < -8) ovf = 1;
      val = (r + 16) % 16;
    end
    data = val;
  endfunction

  task automatic waitResult(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic applyStimulus(input string name, input int op, input int a, input int b,
                               input int ua, input int rpt,
                               output int data, output int ovf, output int lat);
    @(negedge clk);
    cmd_op      = op[2:0];
    cmd_a       = a[3:0];
    cmd_b       = b[3:0];
    cmd_use_acc = ua[0];
    cmd_rpt     = rpt[3:0];
    cmd_valid   = 1'b1;
    res_ready   = 1'b1;
    checkOutput({name, "_ready_before"}, cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    waitResult(lat);
    data = res_data;
    ovf  = res_ovf;
    checkOutput({name, "_sticky"}, ovf_sticky, sticky_m | (ovf & 0));
  endtask

  task automatic finishCommand(input string name);
    @(negedge clk);
    checkOutput({name, "_ready_after"}, cmd_ready, 1);
    checkOutput({name, "_valid_after"}, res_valid, 0);
  endtask

  task automatic noteResult(input int ovf);
`ifdef CORE_SEQ_STICKY_OVF_EN
    if (ovf != 0) sticky_m = 1;
`endif
  endtask

  initial begin
    int data, ovf, lat, exp_data, exp_ovf, a0, seen, op, a, b, ua, rpt;
    total = 0;
    bad = 0;
    acc_m = 0;
    sticky_m = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_a = 4'd0;
    cmd_b = 4'd0;
    cmd_use_acc = 1'b0;
    cmd_rpt = 4'd0;
    res_ready = 1'b1;
    clr_ovf = 1'b0;

    vecs[0] = '{6, 3, 4, 0, 0, 7, 0};
    vecs[1] = '{5, 15, 2, 1, 0, 5, 0};
    vecs[2] = '{6, 1, 2, 0, 2, 7, 0};
    vecs[3] = '{6, 7, 1, 0, 0, 8, 1};
    vecs[4] = '{5, 0, 1, 1, 0, 7, 1};
    vecs[5] = '{6, 0, 1, 0, 15, 0, 1};
    vecs[6] = '{5, 3, 5, 0, 0, 14, 0};
    vecs[7] = '{6, 9, 2, 1, 1, 2, 0};

    #12;
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_res_data", res_data, 0);
    checkOutput("reset_res_ovf", res_ovf, 0);
    checkOutput("reset_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      noteResult(vecs[i].exp_ovf);
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].ua, vecs[i].rpt, data, ovf, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].rpt + 1);
      checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      finishCommand($sformatf("vec%0d", i));
      acc_m = vecs[i].exp_data;
    end

`ifdef CORE_SEQ_STICKY_OVF_EN
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    sticky_m = 0;
    checkOutput("sticky_cleared", ovf_sticky, 0);
    @(negedge clk);
    cmd_op = 3'd6; cmd_a = 4'd7; cmd_b = 4'd1; cmd_use_acc = 1'b0; cmd_rpt = 4'd0;
    cmd_valid = 1'b1;
    clr_ovf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    waitResult(lat);
    checkOutput("set_wins_sticky", ovf_sticky, 1);
    @(negedge clk);
    checkOutput("held_clear_sticky", ovf_sticky, 0);
    clr_ovf = 1'b0;
    acc_m = 8;
`endif

    // Backpressure: result must hold while a second command waits upstream.
    @(negedge clk);
    cmd_op = 3'd6; cmd_a = 4'd2; cmd_b = 4'd3; cmd_use_acc = 1'b0; cmd_rpt = 4'd0;
    cmd_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_a = 4'd1; cmd_b = 4'd1;
    waitResult(lat);
    checkOutput("bp_latency", lat, 1);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_valid_%0d", k), res_valid, 1);
      checkOutput($sformatf("bp_data_%0d", k), res_data, 5);
      checkOutput($sformatf("bp_ovf_%0d", k), res_ovf, 0);
      checkOutput($sformatf("bp_cmd_ready_%0d", k), cmd_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_idle_ready", cmd_ready, 1);
    checkOutput("bp_idle_valid", res_valid, 0);
    @(negedge clk);
    checkOutput("bp_pending_taken", cmd_ready, 0);
    cmd_valid = 1'b0;
    waitResult(lat);
    checkOutput("bp_pending_latency", lat, 1);
    checkOutput("bp_pending_data", res_data, 2);
    finishCommand("bp_pending");
    acc_m = 2;

    for (int i = 0; i < 24; i++) begin
      op  = ($urandom_range(0, 1) == 1) ? 6 : 5;
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      ua  = $urandom_range(0, 1);
      rpt = $urandom_range(0, 4);
      a0  = (ua == 1) ? acc_m : a;
      modelRun(op, a0, b, rpt, exp_data, exp_ovf);
      noteResult(exp_ovf);
      applyStimulus($sformatf("rnd%0d", i), op, a, b, ua, rpt, data, ovf, lat);
      checkOutput($sformatf("rnd%0d_latency", i), lat, rpt + 1);
      checkOutput($sformatf("rnd%0d_data", i), data, exp_data);
      checkOutput($sformatf("rnd%0d_ovf", i), ovf, exp_ovf);
      finishCommand($sformatf("rnd%0d", i));
      acc_m = exp_data;
    end

    // Reset in the 4th RUN cycle of a 16-iteration command.
    @(negedge clk);
    cmd_op = 3'd6; cmd_a = 4'd0; cmd_b = 4'd1; cmd_use_acc = 1'b0; cmd_rpt = 4'd15;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cmd_ready", cmd_ready, 1);
    checkOutput("midrst_res_valid", res_valid, 0);
    checkOutput("midrst_res_data", res_data, 0);
    checkOutput("midrst_res_ovf", res_ovf, 0);
    checkOutput("midrst_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = 0;
    sticky_m = 0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    checkOutput("midrst_no_result", seen, 0);
    applyStimulus("post_rst_acc", 6, 9, 3, 1, 0, data, ovf, lat);
    checkOutput("post_rst_acc_data", data, 3);
    checkOutput("post_rst_acc_ovf", ovf, 0);
    finishCommand("post_rst_acc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
